// File: rtl/taxi_eth_pkg.sv
// Shared Ethernet definitions for the TX completion tracker.
// Status values carried in the host completion tuser bit.
package taxi_eth_pkg;

    localparam logic CPL_STATUS_OK      = 1'b0;
    localparam logic CPL_STATUS_TIMEOUT = 1'b1;

endpackage

// File: rtl/taxi_eth_tx_cpl_tracker_if.sv
// AXI-stream bundle shared by the frame and completion paths of the tracker.
interface taxi_eth_tx_cpl_tracker_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = (DATA_W + 7) / 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
);

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tuser,
        output tready
    );

endinterface

// File: rtl/taxi_eth_tx_cpl_tracker.sv
// Tags outgoing frames with a short MAC tag from an in-order circular pool and
// turns MAC completions (or watchdog timeouts) back into host cookie completions.
module taxi_eth_tx_cpl_tracker
    import taxi_eth_pkg::*;
#(
    parameter int          TAG_W       = 4,
    parameter int          COOKIE_W    = 16,
    parameter int          CPL_DATA_W  = 96,
    parameter int unsigned TIMEOUT_CYC = 2**20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    taxi_eth_tx_cpl_tracker_if.slave  s_axis_tx,
    taxi_eth_tx_cpl_tracker_if.master m_axis_tx,
    taxi_eth_tx_cpl_tracker_if.slave  s_axis_cpl,
    taxi_eth_tx_cpl_tracker_if.master m_axis_cpl,
    output logic [TAG_W:0]         stat_outstanding,
    output logic                   stat_cpl_unexpected,
    output logic                   stat_timeout
);

    localparam int DEPTH   = 2**TAG_W;
    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [TAG_W-1:0]    wr_ptr;
    logic [TAG_W-1:0]    rd_ptr;
    logic [TAG_W:0]      count;
    logic                frame_active;
    logic [TIMER_W-1:0]  timer;
    logic [COOKIE_W-1:0] cookie_table [DEPTH];

    logic                  cpl_valid;
    logic [CPL_DATA_W-1:0] cpl_data;
    logic [COOKIE_W-1:0]   cpl_cookie;
    logic                  cpl_user;

    logic tx_gate, tx_xfer, tx_alloc, tx_end;
    logic cpl_free, cpl_xfer, cpl_match, cpl_drop, timeout_fire, retire;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tx_gate      = 1'b0;
        cpl_match    = 1'b0;
        timeout_fire = 1'b0;
        // A new frame may only start while a tag is free; later beats never stall on the pool.
        if (frame_active || (count < (TAG_W+1)'(DEPTH))) begin
            tx_gate = 1'b1;
        end
        if (cpl_xfer && (count != '0) && (s_axis_cpl.tid == rd_ptr)) begin
            cpl_match = 1'b1;
        end
        if ((TIMEOUT_CYC != 0) && (count != '0) && (timer == TIMER_MAX) && cpl_free && !cpl_match) begin
            timeout_fire = 1'b1;
        end
    end

    assign tx_xfer  = s_axis_tx.tvalid && s_axis_tx.tready;
    assign tx_alloc = tx_xfer && !frame_active;
    assign tx_end   = tx_xfer && s_axis_tx.tlast;
    assign cpl_free = !cpl_valid || m_axis_cpl.tready;
    assign cpl_xfer = s_axis_cpl.tvalid && cpl_free;
    assign cpl_drop = cpl_xfer && !cpl_match;
    assign retire   = cpl_match || timeout_fire;

    assign m_axis_tx.tdata  = s_axis_tx.tdata;
    assign m_axis_tx.tkeep  = s_axis_tx.tkeep;
    assign m_axis_tx.tlast  = s_axis_tx.tlast;
    assign m_axis_tx.tuser  = s_axis_tx.tuser;
    assign m_axis_tx.tid    = wr_ptr;
    assign m_axis_tx.tvalid = s_axis_tx.tvalid && tx_gate;
    assign s_axis_tx.tready = m_axis_tx.tready && tx_gate;

    assign s_axis_cpl.tready = cpl_free;
    assign m_axis_cpl.tvalid = cpl_valid;
    assign m_axis_cpl.tdata  = cpl_data;
    assign m_axis_cpl.tid    = cpl_cookie;
    assign m_axis_cpl.tuser  = cpl_user;
    assign m_axis_cpl.tkeep  = '1;
    assign m_axis_cpl.tlast  = 1'b1;

    assign stat_outstanding = count;

    // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frame_active <= 1'b0;
        end else begin
            if (tx_xfer) begin
                frame_active <= !s_axis_tx.tlast;
            end
            if (tx_end) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (tx_alloc && !retire) begin
                count <= count + 1'b1;
            end else if (!tx_alloc && retire) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the cookie table has no reset; an entry is always written before it can be retired.
    always_ff @(posedge clk) begin
        if (tx_alloc) begin
            cookie_table[wr_ptr] <= s_axis_tx.tid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpl_valid           <= 1'b0;
            cpl_data            <= '0;
            cpl_cookie          <= '0;
            cpl_user            <= CPL_STATUS_OK;
            stat_cpl_unexpected <= 1'b0;
            stat_timeout        <= 1'b0;
        end else begin
            stat_cpl_unexpected <= cpl_drop;
            stat_timeout        <= timeout_fire;
            if (cpl_match) begin
                cpl_valid  <= 1'b1;
                cpl_data   <= s_axis_cpl.tdata;
                cpl_cookie <= cookie_table[rd_ptr];
                cpl_user   <= CPL_STATUS_OK;
            end else if (timeout_fire) begin
                cpl_valid  <= 1'b1;
                cpl_data   <= '0;
                cpl_cookie <= cookie_table[rd_ptr];
                cpl_user   <= CPL_STATUS_TIMEOUT;
            end else if (m_axis_cpl.tready) begin
                cpl_valid <= 1'b0;
            end
        end
    end

    // Watchdog on the oldest tag; saturates while the output register is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if ((count == '0) || retire) begin
            timer <= '0;
        end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_taxi_eth_tx_cpl_tracker.sv
// Randomised and directed bench for the TX completion tracker, checked every
// cycle against a queue-based model of the tag pool.
module tb_taxi_eth_tx_cpl_tracker;

    localparam int TAG_W = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    taxi_eth_tx_cpl_tracker_if #(.DATA_W(8),  .ID_W(16), .USER_W(1))            s_tx ();
    taxi_eth_tx_cpl_tracker_if #(.DATA_W(8),  .ID_W(TAG_W), .USER_W(1))         m_tx ();
    taxi_eth_tx_cpl_tracker_if #(.DATA_W(96), .KEEP_W(1), .ID_W(TAG_W), .USER_W(1)) s_cpl ();
    taxi_eth_tx_cpl_tracker_if #(.DATA_W(96), .ID_W(16), .USER_W(1))            m_cpl ();

    logic [TAG_W:0] stat_outstanding;
    logic           stat_cpl_unexpected;
    logic           stat_timeout;

    logic        tx_valid = 0, tx_last = 0, tx_user = 0, mtx_ready = 1;
    logic [7:0]  tx_data = 0;
    logic [15:0] tx_cookie = 0;
    logic        cpl_valid = 0, mcpl_ready = 1;
    logic [1:0]  cpl_tid = 0;
    logic [95:0] cpl_ts = 0;

    assign s_tx.tvalid  = tx_valid;
    assign s_tx.tdata   = tx_data;
    assign s_tx.tkeep   = 1'b1;
    assign s_tx.tlast   = tx_last;
    assign s_tx.tid     = tx_cookie;
    assign s_tx.tuser   = tx_user;
    assign m_tx.tready  = mtx_ready;
    assign s_cpl.tvalid = cpl_valid;
    assign s_cpl.tdata  = cpl_ts;
    assign s_cpl.tkeep  = 1'b1;
    assign s_cpl.tlast  = 1'b1;
    assign s_cpl.tid    = cpl_tid;
    assign s_cpl.tuser  = 1'b0;
    assign m_cpl.tready = mcpl_ready;

    taxi_eth_tx_cpl_tracker #(
        .TAG_W(TAG_W), .COOKIE_W(16), .CPL_DATA_W(96), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .s_axis_tx           (s_tx),
        .m_axis_tx           (m_tx),
        .s_axis_cpl          (s_cpl),
        .m_axis_cpl          (m_cpl),
        .stat_outstanding    (stat_outstanding),
        .stat_cpl_unexpected (stat_cpl_unexpected),
        .stat_timeout        (stat_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: outstanding cookies oldest-first, plus tag counters and the pending output.
    logic [15:0] q[$];
    int          wr_tag, rd_tag, wait_cyc;
    bit          active;
    bit          out_valid, out_user, unexp_p, to_p;
    logic [95:0] out_data;
    logic [15:0] out_cookie;
    bit          last_txx, last_cx;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake not seen within cycle budget (t=%0t)", name, $time);
    endtask

    task automatic model_reset();
        q.delete();
        wr_tag = 0; rd_tag = 0; wait_cyc = 0; active = 0;
        out_valid = 0; out_user = 0; out_data = '0; out_cookie = '0;
        unexp_p = 0; to_p = 0; last_txx = 0; last_cx = 0;
    endtask

    task automatic model_step();
        int n = q.size();
        bit tx_ok = active || (n < DEPTH);
        bit txx = tx_valid && mtx_ready && tx_ok;
        bit crdy = !out_valid || mcpl_ready;
        bit cx = cpl_valid && crdy;
        bit match = cx && (n > 0) && (cpl_tid == rd_tag[1:0]);
        bit to = (n > 0) && (wait_cyc == TMO - 1) && crdy && !match;
        if (out_valid && mcpl_ready) out_valid = 0;
        if (match) begin
            out_valid = 1; out_data = cpl_ts; out_cookie = q.pop_front(); out_user = 0;
            rd_tag = (rd_tag + 1) % DEPTH;
        end else if (to) begin
            out_valid = 1; out_data = '0; out_cookie = q.pop_front(); out_user = 1;
            rd_tag = (rd_tag + 1) % DEPTH;
        end
        if (txx && !active) q.push_back(tx_cookie);
        if (txx) begin
            active = !tx_last;
            if (tx_last) wr_tag = (wr_tag + 1) % DEPTH;
        end
        if (n == 0 || match || to) wait_cyc = 0;
        else if (wait_cyc < TMO - 1) wait_cyc++;
        unexp_p = cx && !match;
        to_p = to;
        last_txx = txx;
        last_cx = cx;
    endtask

    task automatic compare();
        int n = q.size();
        bit tx_ok = active || (n < DEPTH);
        check("s_tx_tready", s_tx.tready, mtx_ready && tx_ok);
        check("m_tx_tvalid", m_tx.tvalid, tx_valid && tx_ok);
        if (tx_valid) begin
            check("m_tx_tid", m_tx.tid, wr_tag[1:0]);
            check("m_tx_tdata", m_tx.tdata, tx_data);
            check("m_tx_tlast", m_tx.tlast, tx_last);
            check("m_tx_tuser", m_tx.tuser, tx_user);
        end
        check("s_cpl_tready", s_cpl.tready, !out_valid || mcpl_ready);
        check("m_cpl_tvalid", m_cpl.tvalid, out_valid);
        if (out_valid) begin
            check("m_cpl_tdata", m_cpl.tdata, out_data);
            check("m_cpl_cookie", m_cpl.tid, out_cookie);
            check("m_cpl_tuser", m_cpl.tuser, out_user);
        end
        check("stat_outstanding", stat_outstanding, n);
        check("stat_cpl_unexpected", stat_cpl_unexpected, unexp_p);
        check("stat_timeout", stat_timeout, to_p);
    endtask

    // Called at a negedge with inputs already set; returns at the following negedge.
    task automatic cycle();
        #1;
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic tx_frame(input logic [15:0] cookie, input int beats, input int exp_tid);
        for (int b = 0; b < beats; b++) begin
            int budget = 0;
            tx_valid = 1; tx_cookie = cookie; tx_data = 8'($urandom);
            tx_last = (b == beats - 1); tx_user = 0;
            if (exp_tid >= 0) begin
                #1;
                check("lit_tx_tid", m_tx.tid, exp_tid);
            end
            do begin cycle(); budget++; end while (!last_txx && budget < 300);
            if (!last_txx) bound_fail("tx_beat");
        end
        tx_valid = 0;
    endtask

    task automatic cpl_send(input logic [1:0] tid, input logic [95:0] ts);
        int budget = 0;
        cpl_valid = 1; cpl_tid = tid; cpl_ts = ts;
        do begin cycle(); budget++; end while (!last_cx && budget < 300);
        if (!last_cx) bound_fail("cpl_accept");
        cpl_valid = 0;
    endtask

    task automatic apply_reset();
        tx_valid = 0; cpl_valid = 0; tx_last = 0;
        rst_n = 0;
        #1;
        check("rst_m_tx_tvalid", m_tx.tvalid, 0);
        check("rst_m_cpl_tvalid", m_cpl.tvalid, 0);
        check("rst_outstanding", stat_outstanding, 0);
        check("rst_unexpected", stat_cpl_unexpected, 0);
        check("rst_timeout", stat_timeout, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        mtx_ready = 1; mcpl_ready = 1;
    endtask

    initial begin
        int beats_left = 0;
        int cpl_pct;
        model_reset();
        #2;
        apply_reset();

        // Single three-beat frame and its completion.
        tx_frame(16'hBEEF, 3, 0);
        #1;
        check("t1_outstanding_1", stat_outstanding, 1);
        cpl_send(2'd0, 96'h1234);
        #1;
        check("t1_cpl_valid", m_cpl.tvalid, 1);
        check("t1_cpl_cookie", m_cpl.tid, 16'hBEEF);
        check("t1_cpl_tdata", m_cpl.tdata, 96'h1234);
        check("t1_cpl_tuser", m_cpl.tuser, 0);
        check("t1_outstanding_0", stat_outstanding, 0);

        // Unexpected completions: empty pool, then wrong tag.
        cpl_send(2'd0, 96'h5);
        #1;
        check("t3_unexp_empty", stat_cpl_unexpected, 1);
        check("t3_no_emit_empty", m_cpl.tvalid, 0);
        tx_frame(16'h1111, 1, 1);
        cpl_send(2'd3, 96'h6);
        #1;
        check("t3_unexp_tag", stat_cpl_unexpected, 1);
        check("t3_no_emit_tag", m_cpl.tvalid, 0);
        check("t3_still_outstanding", stat_outstanding, 1);
        cpl_send(2'd1, 96'h77);
        #1;
        check("t3_good_cookie", m_cpl.tid, 16'h1111);

        // Watchdog: single frame on tag 2, no completion.
        tx_frame(16'hCAFE, 1, 2);
        for (int i = 0; i < TMO - 1; i++) cycle();
        #1;
        check("t4_not_yet", m_cpl.tvalid, 0);
        cycle();
        #1;
        check("t4_to_valid", m_cpl.tvalid, 1);
        check("t4_to_tuser", m_cpl.tuser, 1);
        check("t4_to_tdata", m_cpl.tdata, 96'h0);
        check("t4_to_cookie", m_cpl.tid, 16'hCAFE);
        check("t4_to_pulse", stat_timeout, 1);
        cpl_send(2'd2, 96'h99);
        #1;
        check("t4_late_unexp", stat_cpl_unexpected, 1);

        // Output backpressure with three completions queued (tags 3,0,1).
        mcpl_ready = 0;
        tx_frame(16'hA1A1, 2, 3);
        tx_frame(16'hA2A2, 1, 0);
        tx_frame(16'hA3A3, 1, 1);
        cpl_send(2'd3, 96'h31);
        cpl_valid = 1; cpl_tid = 2'd0; cpl_ts = 96'h32;
        for (int i = 0; i < 20; i++) cycle();
        #1;
        check("t5_held_valid", m_cpl.tvalid, 1);
        check("t5_held_cookie", m_cpl.tid, 16'hA1A1);
        check("t5_held_tdata", m_cpl.tdata, 96'h31);
        check("t5_backpressure", s_cpl.tready, 0);
        mcpl_ready = 1;
        cpl_send(2'd0, 96'h32);
        #1;
        check("t5_second_cookie", m_cpl.tid, 16'hA2A2);
        cpl_send(2'd1, 96'h33);
        #1;
        check("t5_third_cookie", m_cpl.tid, 16'hA3A3);
        cycle();

        // Reset mid-frame with two tags outstanding and a completion held.
        tx_frame(16'h6161, 1, 2);
        tx_frame(16'h6262, 1, 3);
        mcpl_ready = 0;
        cpl_send(2'd2, 96'h61);
        tx_valid = 1; tx_cookie = 16'h6363; tx_last = 0; tx_data = 8'h5A;
        cycle();
        #2;
        apply_reset();

        // Pool exhaustion with TAG_W=2: four frames fill it, the fifth waits for tag 0.
        for (int i = 0; i < DEPTH; i++) tx_frame(16'h0020 + 16'(i), 1, i);
        #1;
        check("t2_outstanding_4", stat_outstanding, 4);
        tx_valid = 1; tx_cookie = 16'h0024; tx_last = 0; tx_data = 8'h11;
        #1;
        check("t2_stall_ready", s_tx.tready, 0);
        check("t2_stall_valid", m_tx.tvalid, 0);
        for (int i = 0; i < 3; i++) cycle();
        cpl_valid = 1; cpl_tid = 2'd0; cpl_ts = 96'h20;
        cycle();
        cpl_valid = 0;
        #1;
        check("t2_resume_ready", s_tx.tready, 1);
        check("t2_resume_tid", m_tx.tid, 0);
        begin
            int budget = 0;
            do begin cycle(); budget++; end while (!last_txx && budget < 300);
            if (!last_txx) bound_fail("t2_first_beat");
        end
        tx_frame(16'h0024, 1, 0);
        for (int i = 1; i <= DEPTH; i++) cpl_send(2'(i), 96'h200 + 96'(i));
        cycle();

        // Randomised traffic: busy completions first, then sparse ones so timeouts occur.
        for (int phase = 0; phase < 2; phase++) begin
            cpl_pct = (phase == 0) ? 35 : 2;
            for (int c = 0; c < ((phase == 0) ? 2000 : 1500); c++) begin
                if (!tx_valid && $urandom_range(0, 99) < 40) begin
                    if (beats_left == 0) begin
                        beats_left = $urandom_range(1, 4);
                        tx_cookie = 16'($urandom);
                    end
                    tx_valid = 1;
                    tx_data = 8'($urandom);
                    tx_user = 1'($urandom);
                    tx_last = (beats_left == 1);
                end
                mtx_ready = ($urandom_range(0, 99) < 80);
                if (!cpl_valid && $urandom_range(0, 99) < cpl_pct) begin
                    cpl_valid = 1;
                    cpl_tid = ($urandom_range(0, 99) < 85) ? rd_tag[1:0] : 2'($urandom);
                    cpl_ts = {$urandom, $urandom, $urandom};
                end
                mcpl_ready = ($urandom_range(0, 99) < 70);
                cycle();
                if (last_txx) begin
                    tx_valid = 0;
                    beats_left--;
                end
                if (last_cx) cpl_valid = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
